// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a START/DATA/STOP shifter on txd, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_buffered #(
   parameter int CLK_PER_HALF_BIT = 30,
   parameter int FIFO_DEPTH_LOG2  = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   output logic                     full,
   output logic                     drop,
   output logic [FIFO_DEPTH_LOG2:0] count,
   output logic                     busy,
   output logic                     txd
);
   // state  | meaning
   // IDLE   | line high, waiting for a queued byte
   // START  | start bit (txd=0) for one bit period
   // DATA   | data bits, LSB first, one bit period each
   // PARITY | even parity bit (only with UART_TX_PARITY_EN)
   // STOP   | stop bit (txd=1); chains straight into START if bytes are queued

   localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
   localparam int TW      = $clog2(BIT_CYC);
   localparam int DEPTH   = 2 ** FIFO_DEPTH_LOG2;
   localparam logic [TW-1:0]              TIMER_LAST = TW'(BIT_CYC - 1);
   localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_CNT  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
`ifdef UART_TX_PARITY_EN
      , ST_PARITY
`endif
   } state_t;

   state_t                   state_q, state_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic [2:0]               bit_idx_q, bit_idx_d;
   logic [7:0]               shift_q, shift_d;
   logic                     txd_q, txd_d;
   logic                     drop_q, drop_d;
   logic [FIFO_DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]               mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
   logic                     parity_q, parity_d;
`endif

   logic [FIFO_DEPTH_LOG2:0] count_w;
   logic                     full_w;
   logic                     push;
   logic                     pop;
   logic                     timer_end;
   logic [7:0]               head;

   always_comb begin
      count_w   = wr_ptr_q - rd_ptr_q;
      full_w    = (count_w == DEPTH_CNT);
      push      = wr_en && !full_w;
      drop_d    = wr_en && full_w;
      head      = mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
      timer_end = (timer_q == TIMER_LAST);

      state_d   = state_q;
      timer_d   = timer_end ? '0 : timer_q + TW'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      txd_d     = txd_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            txd_d   = 1'b1;
            if (count_w != '0) begin
               pop     = 1'b1;
               shift_d = head;
               txd_d   = 1'b0;
               state_d = ST_START;
`ifdef UART_TX_PARITY_EN
               parity_d = ^head;
`endif
            end
         end
         ST_START: begin
            if (timer_end) begin
               txd_d     = shift_q[0];
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (timer_end) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  txd_d   = parity_q;
                  state_d = ST_PARITY;
`else
                  txd_d   = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
                  txd_d     = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (timer_end) begin
               txd_d   = 1'b1;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (timer_end) begin
               // back-to-back frames: reload here so no idle cycle separates them
               if (count_w != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
                  txd_d   = 1'b0;
                  state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^head;
`endif
               end else begin
                  txd_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      wr_ptr_d = wr_ptr_q + (FIFO_DEPTH_LOG2 + 1)'(push);
      rd_ptr_d = rd_ptr_q + (FIFO_DEPTH_LOG2 + 1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         drop_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         drop_q    <= drop_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // storage needs no reset; pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= wr_data;
   end

   assign full  = full_w;
   assign count = count_w;
   assign drop  = drop_q;
   assign busy  = (state_q != ST_IDLE);
   assign txd   = txd_q;

endmodule
